cam_frame_reader: RTL and testbench
===================================

// Module: cam_frame_reader
// PURPOSE
//  Read side of the camera frame buffer. Walks the 160x120 RGB333 buffer on mem_clk
//  through the buffer's synchronous read port (addr -> q, 1-cycle latency) and emits a
//  raster-ordered pixel stream with valid/ready handshake to downstream key-detection logic.
//  One frame is scanned per start pulse.
// PARAMETERS
//  FB_W    160  pixels per row (x = 0..FB_W-1, x field 8 bits)
//  FB_H    120  rows per frame (y = 0..FB_H-1, y field 7 bits)
//  RD_LAT  1    mem_clk cycles from addr to valid q
// PORTS
//  mem_clk    in   1   clock
//  rst        in   1   reset, asynchronous, active-low
//  start      in   1   1-cycle pulse: begin scanning a frame
//  abort      in   1   synchronous: drop current scan, return to IDLE
//  busy       out  1   high from accepted start until done/abort
//  done       out  1   1-cycle pulse after last pixel handshake
//  addr       out  32  read address to frame buffer: {7'b0, y[6:0], 8'b0, x[7:0], 2'b00}
//  q          in   9   read data {R[8:6], G[5:3], B[2:0]}
//  pix_data   out  9   pixel payload (see CONFIGURATION)
//  pix_x      out  8   pixel column
//  pix_y      out  7   pixel row
//  pix_sof    out  1   first pixel of frame (x=0,y=0)
//  pix_eol    out  1   last pixel of row (x=FB_W-1)
//  pix_eof    out  1   last pixel of frame
//  pix_valid  out  1   stream valid
//  pix_ready  in   1   stream ready
// BEHAVIOUR
//  - Reset (rst low, async): busy,done,pix_valid,sof/eol/eof=0; addr=0; x/y counters=0; FSM IDLE.
//  - FSM: IDLE -start-> SCAN -last addr issued-> DRAIN -last pixel accepted-> IDLE (done=1).
//    abort in any state -> IDLE next cycle, buffer flushed, pix_valid=0, no done. abort wins over start.
//  - start while busy ignored. addr held at 0 in IDLE.
//  - SCAN: issue one address per cycle when credit allows; read x/y increment x first,
//    x wraps FB_W-1->0 with y+1. Tag (x,y,sof,eol,eof) travels in RD_LAT-deep pipe beside read.
//  - Credit: outstanding reads + buffered pixels <= 2; no address issued otherwise. No pixel ever lost
//    or duplicated under arbitrary pix_ready.
//  - Output handshake: transfer when pix_valid & pix_ready. While pix_valid & !pix_ready all pix_*
//    held stable. pix_valid never depends on pix_ready.
//  - Latency: start at cycle 0 -> first addr cycle 1 -> first pix_valid cycle 1+RD_LAT+1 (registered out).
//  - Full throughput: with pix_ready held high, one pixel per cycle; frame = FB_W*FB_H transfers.
//  - done asserted the cycle after eof handshake; busy drops same cycle.
// CONFIGURATION
//  CAM_RD_MONO_EN defined: pix_data = {4'b0, R+G+B} (5-bit sum, 0..21), registered with the tag.
//  Not defined: pix_data = q passed through unchanged (RGB333). Timing/handshake identical both ways.
// STRUCTURE
//  Package cam_pkg: FB_W/FB_H defaults, X_W=8, Y_W=7, PIX_W=9, pix_tag_t {x,y,sof,eol,eof},
//    addr packing function fb_addr(x,y).
//  Sub-module cam_pix_fifo: 2-entry FIFO of {pix_tag_t,data}, push from read pipe, pop on handshake,
//    full/empty flags, flush input driven by abort.
// TESTING
//  1 ready=1, start: 19200 pixels, one/cycle, first pix_valid 3 cycles after start; sof on (0,0),
//    eol on every x=159, eof at (159,119); done 1 cycle later.
//  2 Model returns q={x[2:0],y[2:0],x[5:3]}: every pix_data matches its (x,y); addr for (5,3)=0x000C0014.
//  3 Random pix_ready (50%): no drop/dup, stream ordered, payload stable while stalled; outstanding<=2.
//  4 abort at pixel 1000 with ready=0: next cycle busy=0, pix_valid=0, no done; new start restarts at (0,0).
//  5 start while busy and start+abort same cycle: start ignored / abort wins, no second frame.
//  6 rst low mid-frame: all outputs 0 immediately; with CAM_RD_MONO_EN q=9'h1FF -> pix_data=9'd21.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame-buffer read side.
// Used by cam_pix_fifo and cam_frame_reader.
package cam_pkg;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int PIX_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           sof;
        logic           eol;
        logic           eof;
    } pix_tag_t;

    typedef struct packed {
        pix_tag_t         tag;
        logic [PIX_W-1:0] data;
    } pix_ent_t;

    // Word address of pixel (x,y) in the frame buffer.
    function automatic logic [31:0] fb_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return {7'b0, y, 8'b0, x, 2'b00};
    endfunction

    // Grey level as the plain sum of the three 3-bit channels (0..21).
    function automatic logic [PIX_W-1:0] mono_sum(input logic [PIX_W-1:0] rgb);
        return {4'b0, 5'(rgb[8:6]) + 5'(rgb[5:3]) + 5'(rgb[2:0])};
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Two-entry pixel FIFO between the frame-buffer read pipe and the stream output.
// Entry 0 is always the head, so the output fields come straight from a register.
module cam_pix_fifo
    import cam_pkg::*;
(
    input  logic     mem_clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  pix_ent_t din,
    input  logic     pop,
    output pix_ent_t head,
    output logic     full,
    output logic     empty
);

    pix_ent_t   mem0_r;
    pix_ent_t   mem1_r;
    logic [1:0] cnt_r;
    logic       pop_ok_s;
    logic       push_ok_s;

    assign pop_ok_s  = pop && (cnt_r != 2'd0);
    assign push_ok_s = push && ((cnt_r != 2'd2) || pop_ok_s);

    // Shift-register storage: pops move entry 1 into the head slot.
    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            mem0_r <= '0;
            mem1_r <= '0;
            cnt_r  <= 2'd0;
        end else if (flush) begin
            cnt_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (cnt_r == 2'd0) mem0_r <= din;
                    else               mem1_r <= din;
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    mem0_r <= mem1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        mem0_r <= din;
                    end else begin
                        mem0_r <= mem1_r;
                        mem1_r <= din;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign head  = mem0_r;
    assign full  = (cnt_r == 2'd2);
    assign empty = (cnt_r == 2'd0);

endmodule

// File: rtl/cam_frame_reader.sv
// Scans the 160x120 RGB333 frame buffer once per start and streams it out in raster order.
// Optional CAM_RD_MONO_EN replaces the RGB payload with the channel sum.
module cam_frame_reader
    import cam_pkg::*;
(
    input  logic             mem_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [31:0]      addr,
    input  logic [PIX_W-1:0] q,
    output logic [PIX_W-1:0] pix_data,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic             pix_valid,
    input  logic             pix_ready
);

    localparam logic [X_W-1:0] X_LAST = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_H - 1);

    rd_state_t        state_r, state_nxt;
    logic [X_W-1:0]   x_r, x_nxt_s;
    logic [Y_W-1:0]   y_r, y_nxt_s;
    logic [31:0]      addr_r;
    logic             q_vld_r;
    pix_tag_t         q_tag_r, tag_s;
    logic             done_r, done_nxt;
    logic             pop_s, issue_s, x_last_s, y_last_s;
    logic [1:0]       buf_s;
    logic [2:0]       occ_s;
    logic [PIX_W-1:0] pix_in_s;
    pix_ent_t         head_s;
    logic             fifo_full_s, fifo_empty_s;

`ifdef CAM_RD_MONO_EN
    assign pix_in_s = mono_sum(q);
`else
    assign pix_in_s = q;
`endif

    assign pop_s    = !fifo_empty_s && pix_ready;
    assign x_last_s = (x_r == X_LAST);
    assign y_last_s = (y_r == Y_LAST);
    assign buf_s    = fifo_full_s ? 2'd2 : (fifo_empty_s ? 2'd0 : 2'd1);
    // Reads in flight plus buffered pixels, after this cycle's pop, must leave room for one more.
    assign occ_s    = {1'b0, buf_s} + {2'b00, q_vld_r};
    assign issue_s  = (state_r == ST_SCAN) && (occ_s < (3'd2 + {2'b00, pop_s}));

    // Next-state, next read position and done pulse.
    always_comb begin
        state_nxt = state_r;
        done_nxt  = 1'b0;
        x_nxt_s   = x_last_s ? {X_W{1'b0}} : (x_r + {{(X_W-1){1'b0}}, 1'b1});
        y_nxt_s   = (!x_last_s) ? y_r : (y_last_s ? {Y_W{1'b0}} : (y_r + {{(Y_W-1){1'b0}}, 1'b1}));
        tag_s     = '{x: x_r, y: y_r, sof: (x_r == {X_W{1'b0}}) && (y_r == {Y_W{1'b0}}),
                      eol: x_last_s, eof: x_last_s && y_last_s};
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt = start ? ST_SCAN : ST_IDLE;
                ST_SCAN:  state_nxt = (issue_s && x_last_s && y_last_s) ? ST_DRAIN : ST_SCAN;
                ST_DRAIN: begin
                    if (pop_s && head_s.tag.eof) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, read counters, address register and the one-deep tag pipe beside the read.
    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            addr_r  <= 32'd0;
            q_vld_r <= 1'b0;
            q_tag_r <= '0;
        end else begin
            state_r <= state_nxt;
            done_r  <= done_nxt;
            if (abort || (state_r == ST_IDLE)) begin
                x_r     <= '0;
                y_r     <= '0;
                addr_r  <= 32'd0;
                q_vld_r <= 1'b0;
            end else begin
                q_vld_r <= issue_s;
                if (issue_s) begin
                    q_tag_r <= tag_s;
                    x_r     <= x_nxt_s;
                    y_r     <= y_nxt_s;
                    addr_r  <= (x_last_s && y_last_s) ? 32'd0 : fb_addr(x_nxt_s, y_nxt_s);
                end
            end
        end
    end

    cam_pix_fifo u_fifo (
        .mem_clk (mem_clk),
        .rst     (rst),
        .flush   (abort),
        .push    (q_vld_r),
        .din     ('{tag: q_tag_r, data: pix_in_s}),
        .pop     (pop_s),
        .head    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign addr      = addr_r;
    assign pix_valid = !fifo_empty_s;
    assign pix_data  = head_s.data;
    assign pix_x     = head_s.tag.x;
    assign pix_y     = head_s.tag.y;
    assign pix_sof   = head_s.tag.sof && !fifo_empty_s;
    assign pix_eol   = head_s.tag.eol && !fifo_empty_s;
    assign pix_eof   = head_s.tag.eof && !fifo_empty_s;

endmodule

// File: tb/tb_cam_frame_reader.sv
// Scoreboard bench for cam_frame_reader: a frame model fills an expected queue on each
// accepted start; a negedge monitor pops and compares on every stream handshake.
module tb_cam_frame_reader;

    logic        mem_clk = 1'b0;
    logic        rst, start, abort, busy, done;
    logic [31:0] addr;
    logic [8:0]  q, pix_data;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_sof, pix_eol, pix_eof, pix_valid, pix_ready;

    cam_frame_reader dut (
        .mem_clk(mem_clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .addr(addr), .q(q), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        int         x;
        int         y;
        bit         sof;
        bit         eol;
        bit         eof;
        logic [8:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          force_ones = 1'b0;
    int          ready_mode = 1;
    int          frames_done = 0;
    int          n_rx = 0;
    int          cyc = 0;
    int          sof_cyc = 0;
    int          eof_cyc = 0;
    bit          seen_53 = 1'b0;
    bit          done_exp = 1'b0;
    bit          prev_stall = 1'b0;
    logic [26:0] held;

    // Frame buffer model: 1-cycle read of pattern {x[2:0], y[2:0], x[5:3]}.
    initial forever begin
        int ax, ay;
        @(posedge mem_clk);
        ax = int'(addr[9:2]);
        ay = int'(addr[24:18]);
        q <= force_ones ? 9'h1FF : {3'(ax % 8), 3'(ay % 8), 3'((ax / 8) % 8)};
    end

    function automatic logic [8:0] exp_data(input int x, input int y, input bit ones);
        logic [8:0] rgb;
        int r, g, b;
        rgb = ones ? 9'h1FF : {3'(x % 8), 3'(y % 8), 3'((x / 8) % 8)};
        r = int'(rgb[8:6]);
        g = int'(rgb[5:3]);
        b = int'(rgb[2:0]);
`ifdef CAM_RD_MONO_EN
        return 9'(r + g + b);
`else
        return 9'(r * 64 + g * 8 + b);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                sb.push_back('{x: x, y: y, sof: (x == 0 && y == 0), eol: (x == 159),
                               eof: (x == 159 && y == 119), data: exp_data(x, y, force_ones)});
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic do_start(input bit accepted);
        start = 1'b1;
        if (accepted) push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("frame_complete", 64'(frames_done >= target), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Downstream ready pattern: 0 low, 1 high, otherwise random 50%.
    initial forever begin
        @(posedge mem_clk);
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pop on handshake, stall stability, done timing, address format.
    initial forever begin
        exp_t e;
        @(negedge mem_clk);
        cyc++;
        if (!rst) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done", 64'(done), 64'(done_exp));
            if (done_exp) begin
                chk("busy_after_done", 64'(busy), 64'd0);
                frames_done++;
            end
            chk("addr_zero_fields", 64'(addr & 32'hFE03FC03), 64'd0);
            chk("addr_in_frame", 64'((addr[9:2] < 8'd160) && (addr[24:18] < 7'd120)), 64'd1);
            if (addr == 32'h000C0014) seen_53 = 1'b1;
            if (prev_stall) begin
                chk("stall_valid", 64'(pix_valid), 64'd1);
                chk("stall_payload", 64'({pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}), 64'(held));
            end
            done_exp = 1'b0;
            if (pix_valid && pix_ready) begin
                n_rx++;
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pix_x", 64'(pix_x), 64'(e.x));
                    chk("pix_y", 64'(pix_y), 64'(e.y));
                    chk("pix_flags", 64'({pix_sof, pix_eol, pix_eof}), 64'({e.sof, e.eol, e.eof}));
                    chk("pix_data", 64'(pix_data), 64'(e.data));
                    if (e.sof) sof_cyc = cyc;
                    if (e.eof) begin
                        eof_cyc  = cyc;
                        done_exp = !abort;
                    end
                end
            end
            prev_stall = pix_valid && !pix_ready && !abort;
            held = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
        end
    end

    initial begin
        int lat, fd, n, base;
        rst = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_flags", 64'({pix_sof, pix_eol, pix_eof}), 64'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Full-rate frame: latency, throughput, markers, done.
        ready_mode = 1;
        tick();
        seen_53 = 1'b0;
        do_start(1'b1);
        lat = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge mem_clk);
            if (pix_valid) begin
                lat = c;
                break;
            end
        end
        chk("first_valid_latency", 64'(lat), 64'd3);
        wait_frame(1, 25000);
        chk("full_rate_cycles", 64'(eof_cyc - sof_cyc), 64'd19199);
        chk("addr_5_3_seen", 64'(seen_53), 64'd1);

        // Random backpressure frame.
        ready_mode = 2;
        tick();
        do_start(1'b1);
        wait_frame(2, 60000);

        // Abort after 1000 pixels with ready low, then restart.
        ready_mode = 1;
        tick();
        base = n_rx;
        do_start(1'b1);
        n = 0;
        while (n_rx < base + 1000 && n < 5000) begin
            tick();
            n++;
        end
        chk("reached_1000", 64'(n_rx >= base + 1000), 64'd1);
        ready_mode = 0;
        repeat (3) tick();
        fd = frames_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        @(negedge mem_clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(pix_valid), 64'd0);
        repeat (5) tick();
        chk("abort_no_done", 64'(frames_done), 64'(fd));

        // Restart from (0,0) with an ignored start mid-frame.
        ready_mode = 1;
        tick();
        do_start(1'b1);
        repeat (10) tick();
        do_start(1'b0);
        wait_frame(fd + 1, 25000);
        repeat (10) tick();
        chk("single_frame", 64'(frames_done), 64'(fd + 1));

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mem_clk);
            chk("start_abort_busy", 64'(busy), 64'd0);
            chk("start_abort_valid", 64'(pix_valid), 64'd0);
        end

        // Saturated pixels, then asynchronous reset mid-frame.
        force_ones = 1'b1;
        tick();
        do_start(1'b1);
        repeat (30) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy_done_valid", 64'({busy, done, pix_valid}), 64'd0);
        chk("mid_rst_addr", 64'(addr), 64'd0);
        chk("mid_rst_pix", 64'({pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}), 64'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        force_ones = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
